// File: rtl/iter_magnitude_comparator.sv
// ----------------------------------------------------------------------------
// iter_magnitude_comparator
//
// Purpose:
//   Multi-cycle magnitude comparator. It compares operands A and B MSB-first,
//   CHUNK bits per clock, in either signed or unsigned mode, and reports
//   gt/lt/eq. With EARLY_EXIT=1 it finishes on the first differing chunk.
//   Only one operation is in flight at a time. Both sides use a valid/ready
//   handshake.
//
// Parameters:
//   WIDTH      - operand width in bits; must be a multiple of CHUNK
//   CHUNK      - bits compared per cycle (NCHUNK = WIDTH/CHUNK)
//   EARLY_EXIT - 1: stop at the first differing chunk; 0: always NCHUNK cycles
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  operands can be accepted (high only in IDLE)
//   a, b       in   operands A and B, WIDTH bits each
//   is_signed  in   1: two's-complement compare; 0: unsigned compare
//   out_valid  out  result valid; held until the consumer accepts it
//   out_ready  in   consumer accepts the result
//   gt, lt, eq out  A > B, A < B, A == B (exactly one is set when valid)
//   cycles     out  number of compare cycles spent (1..NCHUNK)
// ----------------------------------------------------------------------------
module iter_magnitude_comparator #(
    parameter  int WIDTH      = 8,
    parameter  int CHUNK      = 2,
    parameter  int EARLY_EXIT = 1,
    localparam int NCHUNK     = WIDTH / CHUNK,
    localparam int CW         = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CW-1:0]    cycles
);

    // The chunk index needs at least one bit, even when there is one chunk.
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ax;
    logic [WIDTH-1:0] bx;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic             found;
    logic             cmp_gt;
    logic             cmp_lt;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic             diff;
    logic             any_diff;
    logic             gt_now;
    logic             lt_now;
    logic             finish;

    // Flipping the MSB turns a two's-complement ordering into an unsigned one.
    // After that flip, every chunk can be compared as an unsigned value.
    logic [WIDTH-1:0] sign_flip;
    assign sign_flip = {is_signed, {(WIDTH-1){1'b0}}};

    assign in_ready = (state == IDLE);

    // Pick the chunk currently under comparison and work out whether this
    // cycle ends the operation. A difference already latched by an earlier,
    // more significant chunk always wins over the current chunk.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IW'(i)) begin
                chunk_a = ax[i*CHUNK +: CHUNK];
                chunk_b = bx[i*CHUNK +: CHUNK];
            end
        end
        diff     = (chunk_a != chunk_b);
        any_diff = found | diff;
        gt_now   = found ? cmp_gt : (chunk_a > chunk_b);
        lt_now   = found ? cmp_lt : (chunk_a < chunk_b);
        finish   = ((EARLY_EXIT != 0) && any_diff) || (idx == '0);
    end

    // Main FSM. The visible gt/lt/eq/cycles update only when a result is
    // produced, so they keep their last values after the handoff and while
    // the next operation is still being compared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            cycles    <= '0;
            ax        <= '0;
            bx        <= '0;
            idx       <= '0;
            cnt       <= '0;
            found     <= 1'b0;
            cmp_gt    <= 1'b0;
            cmp_lt    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ax     <= a ^ sign_flip;
                        bx     <= b ^ sign_flip;
                        idx    <= IW'(NCHUNK - 1);
                        cnt    <= '0;
                        found  <= 1'b0;
                        cmp_gt <= 1'b0;
                        cmp_lt <= 1'b0;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    cnt <= cnt + CW'(1);
                    if (diff && !found) begin
                        found  <= 1'b1;
                        cmp_gt <= (chunk_a > chunk_b);
                        cmp_lt <= (chunk_a < chunk_b);
                    end
                    if (finish) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        gt        <= gt_now;
                        lt        <= lt_now;
                        eq        <= !any_diff;
                        cycles    <= cnt + CW'(1);
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_magnitude_comparator.sv
// ----------------------------------------------------------------------------
// tb_iter_magnitude_comparator
//
// Purpose:
//   Self-checking bench for iter_magnitude_comparator. Three instances share
//   the same stimulus:
//     dut 0: WIDTH=8 CHUNK=2 EARLY_EXIT=1
//     dut 1: WIDTH=8 CHUNK=2 EARLY_EXIT=0 (fixed four compare cycles)
//     dut 2: WIDTH=8 CHUNK=8 EARLY_EXIT=1 (single compare cycle)
//   Expected results come from a behavioural model that uses integer
//   arithmetic. A table of known vectors and a few hand-written sequences
//   cover the documented corner cases.
// ----------------------------------------------------------------------------
module tb_iter_magnitude_comparator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       is_signed;

    logic [2:0] ir;
    logic [2:0] ov;
    logic [2:0] gt_o;
    logic [2:0] lt_o;
    logic [2:0] eq_o;
    logic [2:0] cy0;
    logic [2:0] cy1;
    logic [0:0] cy2;

    int total;
    int bad;

    iter_magnitude_comparator #(.WIDTH(8), .CHUNK(2), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(ov[0]),
        .out_ready(out_ready), .gt(gt_o[0]), .lt(lt_o[0]), .eq(eq_o[0]),
        .cycles(cy0)
    );

    iter_magnitude_comparator #(.WIDTH(8), .CHUNK(2), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(ov[1]),
        .out_ready(out_ready), .gt(gt_o[1]), .lt(lt_o[1]), .eq(eq_o[1]),
        .cycles(cy1)
    );

    iter_magnitude_comparator #(.WIDTH(8), .CHUNK(8), .EARLY_EXIT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(ov[2]),
        .out_ready(out_ready), .gt(gt_o[2]), .lt(lt_o[2]), .eq(eq_o[2]),
        .cycles(cy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic       gt;
        logic       lt;
        logic       eq;
        int         cyc;
    } vec_t;

    // The chunk size and early-exit setting of each instance.
    function automatic int chunk_of(input int k);
        return (k == 2) ? 8 : 2;
    endfunction

    function automatic int ee_of(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int cyc_of(input int k);
        case (k)
            0:       return int'(cy0);
            1:       return int'(cy1);
            default: return int'(cy2);
        endcase
    endfunction

    // Reference model. The ordering comes from plain signed or unsigned
    // integer comparison. The cycle count is the 1-based position, counted
    // from the MSB end, of the first chunk that differs after the sign bit
    // is flipped.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                         input logic ms, input int chunk, input int ee,
                         output logic egt, output logic elt,
                         output logic eeq, output int ecyc);
        int va;
        int vb;
        int xa;
        int xb;
        int nch;
        int mask;
        int sh;
        if (ms) begin
            va = int'($signed(ma));
            vb = int'($signed(mb));
        end else begin
            va = int'(ma);
            vb = int'(mb);
        end
        egt  = (va > vb);
        elt  = (va < vb);
        eeq  = (va == vb);
        nch  = 8 / chunk;
        ecyc = nch;
        if (ee != 0) begin
            xa   = int'(ma) ^ (ms ? 128 : 0);
            xb   = int'(mb) ^ (ms ? 128 : 0);
            mask = (1 << chunk) - 1;
            for (int i = 0; i < nch; i++) begin
                sh = 8 - chunk * (i + 1);
                if (((xa >> sh) & mask) != ((xb >> sh) & mask)) begin
                    ecyc = i + 1;
                    break;
                end
            end
        end
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one operation on all three instances at once. The result side is
    // held back until every instance shows out_valid. After that it stays
    // back for another 'hold' cycles, and then one accept cycle follows.
    // Latency is counted in clock cycles. The accept cycle is cycle 0, so the
    // first out_valid=1 cycle should be cycles+1.
    task automatic apply_stimulus(input logic [7:0] ta, input logic [7:0] tb,
                                  input logic ts, input int hold);
        logic egt[3];
        logic elt[3];
        logic eeq[3];
        int   ecyc[3];
        int   lat[3];
        bit   seen[3];
        bit   all_seen;
        int   n;

        for (int k = 0; k < 3; k++) begin
            model(ta, tb, ts, chunk_of(k), ee_of(k), egt[k], elt[k], eeq[k], ecyc[k]);
            seen[k] = 1'b0;
            lat[k]  = 0;
        end

        @(negedge clk);
        check_output("in_ready_before_op", int'(ir), 7);
        a         = ta;
        b         = tb;
        is_signed = ts;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a         = 8'($urandom_range(0, 255));
        b         = 8'($urandom_range(0, 255));
        is_signed = 1'($urandom_range(0, 1));

        n        = 1;
        all_seen = 1'b0;
        while (!all_seen && n < 40) begin
            all_seen = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (ov[k] && !seen[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = n;
                end
                if (!seen[k]) all_seen = 1'b0;
            end
            if (!all_seen) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check_output("result_timeout", int'(all_seen), 1);

        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("latency_dut%0d", k), lat[k], ecyc[k] + 1);
            check_output($sformatf("gt_dut%0d", k), int'(gt_o[k]), int'(egt[k]));
            check_output($sformatf("lt_dut%0d", k), int'(lt_o[k]), int'(elt[k]));
            check_output($sformatf("eq_dut%0d", k), int'(eq_o[k]), int'(eeq[k]));
            check_output($sformatf("onehot_dut%0d", k),
                         int'(gt_o[k]) + int'(lt_o[k]) + int'(eq_o[k]), 1);
            check_output($sformatf("cycles_dut%0d", k), cyc_of(k), ecyc[k]);
        end

        // Backpressure: results must stay put while out_ready is low.
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_output("hold_out_valid", int'(ov), 7);
            check_output("hold_in_ready", int'(ir), 0);
            for (int k = 0; k < 3; k++) begin
                check_output($sformatf("hold_gt_dut%0d", k), int'(gt_o[k]), int'(egt[k]));
                check_output($sformatf("hold_lt_dut%0d", k), int'(lt_o[k]), int'(elt[k]));
                check_output($sformatf("hold_cyc_dut%0d", k), cyc_of(k), ecyc[k]);
            end
        end

        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_output("out_valid_after_accept", int'(ov), 0);
        check_output("in_ready_after_accept", int'(ir), 7);
        check_output("eq_kept_after_accept_dut0", int'(eq_o[0]), int'(eeq[0]));
    endtask

    vec_t vecs[$];

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_out_valid", int'(ov), 0);
        check_output("reset_in_ready", int'(ir), 7);
        check_output("reset_gt", int'(gt_o), 0);
        check_output("reset_lt", int'(lt_o), 0);
        check_output("reset_eq", int'(eq_o), 0);
        check_output("reset_cycles_dut0", cyc_of(0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known vectors for the early-exit, CHUNK=2 instance.
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4});
        vecs.push_back('{8'h40, 8'h35, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{8'h05, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 3});
        vecs.push_back('{8'hCA, 8'h7B, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{8'hCA, 8'h7B, 1'b1, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{8'hCA, 8'hFB, 1'b1, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{8'h20, 8'h17, 1'b0, 1'b1, 1'b0, 1'b0, 2});
        vecs.push_back('{8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 4});
        vecs.push_back('{8'hFE, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 4});

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].s, 0);
            check_output($sformatf("vec%0d_gt", i), int'(gt_o[0]), int'(vecs[i].gt));
            check_output($sformatf("vec%0d_lt", i), int'(lt_o[0]), int'(vecs[i].lt));
            check_output($sformatf("vec%0d_eq", i), int'(eq_o[0]), int'(vecs[i].eq));
            check_output($sformatf("vec%0d_cycles", i), cyc_of(0), vecs[i].cyc);
        end

        // Long backpressure: ten held cycles with in_ready low throughout.
        apply_stimulus(8'h40, 8'h35, 1'b0, 10);
        check_output("bp_cycles_fixed_dut1", cyc_of(1), 4);

        // Reset in the middle of CMP for a=0x05, b=0x08.
        @(negedge clk);
        a         = 8'h05;
        b         = 8'h08;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("midreset_out_valid", int'(ov), 0);
        check_output("midreset_in_ready", int'(ir), 7);
        check_output("midreset_gt", int'(gt_o), 0);
        check_output("midreset_cycles_dut0", cyc_of(0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(8'h20, 8'h17, 1'b0, 0);
        check_output("after_reset_gt", int'(gt_o[0]), 1);
        check_output("after_reset_cycles", cyc_of(0), 2);

        // Random regression in both modes with random result backpressure.
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = {ra[7:4], rb[3:0]};
                default: ;
            endcase
            apply_stimulus(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
